// File: rtl/ipu_stat_pkg.sv
// Shared definitions for image-statistics blocks: publish FSM encoding and
// the values the running statistics restart from at every frame boundary.
package ipu_stat_pkg;

    typedef enum logic {
        ACCUM   = 1'b0,
        PUBLISH = 1'b1
    } stat_state_e;

    // Wide enough for any coordinate or count field; users slice to their width.
    localparam int                     STAT_INIT_W   = 32;
    localparam logic [STAT_INIT_W-1:0] STAT_MIN_INIT = '1;
    localparam logic [STAT_INIT_W-1:0] STAT_MAX_INIT = '0;
    localparam logic [STAT_INIT_W-1:0] STAT_CNT_INIT = '0;

endpackage

// File: rtl/pixel_coord_counter.sv
// Column/row position of the current pixel beat. Advances on valid beats only
// and saturates at the frame edge when line/frame markers go missing.
module pixel_coord_counter
#(
    parameter int P_WIDTH  = 320,
    parameter int P_HEIGHT = 240,
    parameter int P_WCNT_W = 9,
    parameter int P_HCNT_W = 8
)(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                i_valid,
    input  logic                i_last_in_line,
    input  logic                i_last_pix,
    output logic [P_WCNT_W-1:0] o_x,
    output logic [P_HCNT_W-1:0] o_y
);
    import ipu_stat_pkg::*;

    localparam logic [P_WCNT_W-1:0] LP_X_LAST = P_WCNT_W'(P_WIDTH - 1);
    localparam logic [P_HCNT_W-1:0] LP_Y_LAST = P_HCNT_W'(P_HEIGHT - 1);

    logic [P_WCNT_W-1:0] r_x;
    logic [P_HCNT_W-1:0] r_y;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_valid) begin
            if (i_last_pix) begin
                r_x <= '0;
                r_y <= '0;
            end else if (i_last_in_line) begin
                r_x <= '0;
                r_y <= (r_y == LP_Y_LAST) ? r_y : r_y + P_HCNT_W'(1);
            end else begin
                r_x <= (r_x == LP_X_LAST) ? r_x : r_x + P_WCNT_W'(1);
            end
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/binary_bbox_stat.sv
// Bounding box and foreground count of a binary frame, published one cycle
// after the LAST_PIX beat. Define BBOX_CENTROID_SUM_EN to add SUM_X/SUM_Y.
module binary_bbox_stat
    import ipu_stat_pkg::*;
#(
    parameter int P_WIDTH     = 320,
    parameter int P_HEIGHT    = 240,
    parameter int P_WCNT_W    = 9,
    parameter int P_HCNT_W    = 8,
    parameter int P_PIX_CNT_W = 17
)(
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   DIN_VALID,
    input  logic                   DIN,
    input  logic                   LAST_IN_LINE,
    input  logic                   LAST_PIX,
    input  logic [P_PIX_CNT_W-1:0] MIN_COUNT,
    output logic [P_WCNT_W-1:0]    X_MIN,
    output logic [P_WCNT_W-1:0]    X_MAX,
    output logic [P_HCNT_W-1:0]    Y_MIN,
    output logic [P_HCNT_W-1:0]    Y_MAX,
    output logic [P_PIX_CNT_W-1:0] PIX_COUNT,
    output logic                   FOUND,
    output logic                   RESULT_VALID,
    output logic                   NEXT_LAST_PIX
`ifdef BBOX_CENTROID_SUM_EN
    ,
    output logic [P_WCNT_W+P_PIX_CNT_W-1:0] SUM_X,
    output logic [P_HCNT_W+P_PIX_CNT_W-1:0] SUM_Y
`endif
);

    logic [P_WCNT_W-1:0]    w_x;
    logic [P_HCNT_W-1:0]    w_y;
    logic                   w_fg, w_publish, w_found, w_restart;
    logic [P_WCNT_W-1:0]    w_base_xmin, w_base_xmax, w_nxt_xmin, w_nxt_xmax;
    logic [P_HCNT_W-1:0]    w_base_ymin, w_base_ymax, w_nxt_ymin, w_nxt_ymax;
    logic [P_PIX_CNT_W-1:0] w_base_cnt, w_nxt_cnt;

    stat_state_e            r_state;
    logic [P_WCNT_W-1:0]    r_xmin, r_xmax, r_x_min_o, r_x_max_o;
    logic [P_HCNT_W-1:0]    r_ymin, r_ymax, r_y_min_o, r_y_max_o;
    logic [P_PIX_CNT_W-1:0] r_cnt, r_cnt_o;
    logic                   r_found_o, r_result_valid, r_next_last_pix;

    pixel_coord_counter #(
        .P_WIDTH  (P_WIDTH),
        .P_HEIGHT (P_HEIGHT),
        .P_WCNT_W (P_WCNT_W),
        .P_HCNT_W (P_HCNT_W)
    ) u_coord (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .i_valid        (DIN_VALID),
        .i_last_in_line (LAST_IN_LINE),
        .i_last_pix     (LAST_PIX),
        .o_x            (w_x),
        .o_y            (w_y)
    );

    assign w_fg      = DIN_VALID & DIN;
    assign w_publish = DIN_VALID & LAST_PIX;
    // The PUBLISH cycle restarts the stats underneath any beat arriving in it.
    assign w_restart = (r_state == PUBLISH);

    assign w_base_xmin = w_restart ? STAT_MIN_INIT[P_WCNT_W-1:0]    : r_xmin;
    assign w_base_xmax = w_restart ? STAT_MAX_INIT[P_WCNT_W-1:0]    : r_xmax;
    assign w_base_ymin = w_restart ? STAT_MIN_INIT[P_HCNT_W-1:0]    : r_ymin;
    assign w_base_ymax = w_restart ? STAT_MAX_INIT[P_HCNT_W-1:0]    : r_ymax;
    assign w_base_cnt  = w_restart ? STAT_CNT_INIT[P_PIX_CNT_W-1:0] : r_cnt;

    assign w_nxt_xmin = (w_fg && (w_x < w_base_xmin)) ? w_x : w_base_xmin;
    assign w_nxt_xmax = (w_fg && (w_x > w_base_xmax)) ? w_x : w_base_xmax;
    assign w_nxt_ymin = (w_fg && (w_y < w_base_ymin)) ? w_y : w_base_ymin;
    assign w_nxt_ymax = (w_fg && (w_y > w_base_ymax)) ? w_y : w_base_ymax;
    assign w_nxt_cnt  = (w_fg && (w_base_cnt != '1)) ? w_base_cnt + P_PIX_CNT_W'(1) : w_base_cnt;
    assign w_found    = (w_nxt_cnt != '0) && (w_nxt_cnt >= MIN_COUNT);

`ifdef BBOX_CENTROID_SUM_EN
    localparam int LP_SX_W = P_WCNT_W + P_PIX_CNT_W;
    localparam int LP_SY_W = P_HCNT_W + P_PIX_CNT_W;
    logic [LP_SX_W-1:0] w_nxt_sum_x, r_sum_x, r_sum_x_o;
    logic [LP_SY_W-1:0] w_nxt_sum_y, r_sum_y, r_sum_y_o;

    assign w_nxt_sum_x = (w_restart ? STAT_CNT_INIT[LP_SX_W-1:0] : r_sum_x) + (w_fg ? LP_SX_W'(w_x) : '0);
    assign w_nxt_sum_y = (w_restart ? STAT_CNT_INIT[LP_SY_W-1:0] : r_sum_y) + (w_fg ? LP_SY_W'(w_y) : '0);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_sum_x   <= STAT_CNT_INIT[LP_SX_W-1:0];
            r_sum_y   <= STAT_CNT_INIT[LP_SY_W-1:0];
            r_sum_x_o <= '0;
            r_sum_y_o <= '0;
        end else begin
            r_sum_x <= w_nxt_sum_x;
            r_sum_y <= w_nxt_sum_y;
            if (w_publish) begin
                r_sum_x_o <= w_found ? w_nxt_sum_x : '0;
                r_sum_y_o <= w_found ? w_nxt_sum_y : '0;
            end
        end
    end

    assign SUM_X = r_sum_x_o;
    assign SUM_Y = r_sum_y_o;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state         <= ACCUM;
            r_xmin          <= STAT_MIN_INIT[P_WCNT_W-1:0];
            r_xmax          <= STAT_MAX_INIT[P_WCNT_W-1:0];
            r_ymin          <= STAT_MIN_INIT[P_HCNT_W-1:0];
            r_ymax          <= STAT_MAX_INIT[P_HCNT_W-1:0];
            r_cnt           <= STAT_CNT_INIT[P_PIX_CNT_W-1:0];
            r_x_min_o       <= '0;
            r_x_max_o       <= '0;
            r_y_min_o       <= '0;
            r_y_max_o       <= '0;
            r_cnt_o         <= '0;
            r_found_o       <= 1'b0;
            r_result_valid  <= 1'b0;
            r_next_last_pix <= 1'b0;
        end else begin
            r_xmin          <= w_nxt_xmin;
            r_xmax          <= w_nxt_xmax;
            r_ymin          <= w_nxt_ymin;
            r_ymax          <= w_nxt_ymax;
            r_cnt           <= w_nxt_cnt;
            r_result_valid  <= w_publish;
            r_next_last_pix <= w_publish;
            case (r_state)
                ACCUM:   r_state <= w_publish ? PUBLISH : ACCUM;
                PUBLISH: r_state <= w_publish ? PUBLISH : ACCUM;
                default: r_state <= ACCUM;
            endcase
            if (w_publish) begin
                r_x_min_o <= w_found ? w_nxt_xmin : '0;
                r_x_max_o <= w_found ? w_nxt_xmax : '0;
                r_y_min_o <= w_found ? w_nxt_ymin : '0;
                r_y_max_o <= w_found ? w_nxt_ymax : '0;
                r_cnt_o   <= w_nxt_cnt;
                r_found_o <= w_found;
            end
        end
    end

    assign X_MIN         = r_x_min_o;
    assign X_MAX         = r_x_max_o;
    assign Y_MIN         = r_y_min_o;
    assign Y_MAX         = r_y_max_o;
    assign PIX_COUNT     = r_cnt_o;
    assign FOUND         = r_found_o;
    assign RESULT_VALID  = r_result_valid;
    assign NEXT_LAST_PIX = r_next_last_pix;

endmodule

// File: doc/binary_bbox_stat.md
BINARY_BBOX_STAT -- requirements
Module: binary_bbox_stat

Interface
REQ-001 SHALL have parameter P_WIDTH, default 320, frame width in pixels.
REQ-002 SHALL have parameter P_HEIGHT, default 240, frame height in lines.
REQ-003 SHALL have parameter P_WCNT_W, default 9, column counter width.
REQ-004 SHALL have parameter P_HCNT_W, default 8, row counter width.
REQ-005 SHALL have parameter P_PIX_CNT_W, default 17, pixel count width.
REQ-006 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port RSTn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port DIN_VALID  input  1  binary pixel beat valid (from morphology stage VALID).
REQ-009 SHALL have port DIN  input  1  binary pixel, 1 = foreground.
REQ-010 SHALL have port LAST_IN_LINE  input  1  qualifies last beat of a line.
REQ-011 SHALL have port LAST_PIX  input  1  qualifies last beat of a frame.
REQ-012 SHALL have port MIN_COUNT  input  P_PIX_CNT_W  noise-rejection threshold.
REQ-013 SHALL have port X_MIN, X_MAX  output  P_WCNT_W each  bounding-box columns.
REQ-014 SHALL have port Y_MIN, Y_MAX  output  P_HCNT_W each  bounding-box rows.
REQ-015 SHALL have port PIX_COUNT  output  P_PIX_CNT_W  foreground pixel count of last frame.
REQ-016 SHALL have port FOUND  output  1  last frame held an object.
REQ-017 SHALL have port RESULT_VALID  output  1  one-cycle pulse, results updated.
REQ-018 SHALL have port NEXT_LAST_PIX  output  1  one-cycle frame-consumed acknowledge to upstream squeeze logic.

Function
REQ-019 SHALL hold column counter x and row counter y; both advance only on DIN_VALID=1 beats.
REQ-020 SHALL on a valid beat: x+1; with LAST_IN_LINE: x<=0, y+1; with LAST_PIX: x<=0, y<=0.
REQ-021 SHALL saturate x at P_WIDTH-1 and y at P_HEIGHT-1 when line/frame markers are missing.
REQ-022 SHALL, on a valid beat with DIN=1, update running xmin/xmax/ymin/ymax with current (x,y) and increment running count, count saturating at all-ones.
REQ-023 SHALL use two states: ACCUM (collecting) and PUBLISH (one cycle); reset enters ACCUM.
REQ-024 SHALL on a valid LAST_PIX beat move ACCUM->PUBLISH, including that beat's pixel in the statistics.
REQ-025 SHALL in PUBLISH register outputs, assert RESULT_VALID and NEXT_LAST_PIX for exactly that cycle, re-initialise running stats (min=all-ones, max=0, count=0), return to ACCUM.
REQ-026 SHALL accept and accumulate a valid beat arriving during PUBLISH as first beat of next frame (no beat lost; re-init applies before that beat).
REQ-027 SHALL set FOUND=1 iff final count >= MIN_COUNT and count>0; MIN_COUNT sampled in the LAST_PIX cycle.
REQ-028 SHALL drive X_MIN/X_MAX/Y_MIN/Y_MAX to 0 when FOUND=0.
REQ-029 SHALL hold all outputs stable between RESULT_VALID pulses.
REQ-030 SHALL have latency of exactly 1 cycle from LAST_PIX beat to RESULT_VALID.

Reset
REQ-031 SHALL on RSTn=0 clear x, y, running stats, state to ACCUM, all outputs to 0; mid-frame reset discards the partial frame.

Configuration
REQ-032 SHALL, with macro BBOX_CENTROID_SUM_EN defined, add outputs SUM_X (P_WCNT_W+P_PIX_CNT_W bits) and SUM_Y (P_HCNT_W+P_PIX_CNT_W bits), coordinate sums of foreground pixels, published and re-initialised with the other stats, 0 when FOUND=0.
REQ-033 SHALL, without BBOX_CENTROID_SUM_EN, omit those ports and accumulators entirely.

Structure
REQ-034 SHALL place state encoding (ACCUM, PUBLISH) and stat-init constants in shared package ipu_stat_pkg.
REQ-035 SHALL use one sub-module, pixel_coord_counter, for x/y counting and saturation.

Verification
REQ-036 SHALL cover: 4x3 frame, single foreground at (2,1) -> X_MIN=X_MAX=2, Y_MIN=Y_MAX=1, PIX_COUNT=1, FOUND=1 (MIN_COUNT=1).
REQ-037 SHALL cover: all-zero frame -> FOUND=0, bbox=0, PIX_COUNT=0, one RESULT_VALID and NEXT_LAST_PIX pulse.
REQ-038 SHALL cover: 320x240 full-foreground frame -> X 0..319, Y 0..239, PIX_COUNT=76800, RESULT_VALID one cycle after LAST_PIX.
REQ-039 SHALL cover: MIN_COUNT=5 with 4 foreground pixels -> FOUND=0, PIX_COUNT=4.
REQ-040 SHALL cover: back-to-back frames with valid beat in PUBLISH cycle -> second frame's stats include that beat, first frame's unaffected.
REQ-041 SHALL cover: RSTn low mid-frame then clean frame -> results reflect only post-reset frame.
